pfd_loop_filter: RTL and testbench
==================================

// Module: pfd_loop_filter
// PURPOSE
//  Digital loop filter that sits directly downstream of the PFD. Converts
//  flagu/flagd pulses into a signed phase error (pulse width in clk cycles).
//  Runs a proportional-integral update per PFD comparison and drives a
//  saturated DCO control word, plus a lock indicator, to the oscillator stage.
// PARAMETERS
//  CW        10   control word width
//  WW        6    pulse-width counter width; saturates at 2^WW-1
//  KP_SHIFT  2    proportional gain = err <<< KP_SHIFT
//  KI_SHIFT  0    integral gain = err <<< KI_SHIFT
//  CTRL_INIT 512  integrator and ctrl_word value after reset
//  LOCK_TOL  1    max |err| counted as in-lock
//  LOCK_CNT  8    consecutive in-lock updates needed to assert lock
// PORTS
//  clk        in   1   filter clock, rising-edge; much faster than PFD input
//  RESET      in   1   reset RESET, synchronous, active-low
//  flagu      in   1   PFD up pulse, asynchronous to clk
//  flagd      in   1   PFD down pulse, asynchronous to clk
//  ctrl_word  out  CW  DCO control word, unsigned
//  ctrl_valid out  1   one-cycle strobe; ctrl_word updated this cycle
//  phase_err  out  WW+1 signed error of the last update
//  lock       out  1   loop locked
// BEHAVIOUR
//  - Reset (RESET==0 at posedge clk): sync flops=0, state=IDLE, width=0,
//    integ=CTRL_INIT, ctrl_word=CTRL_INIT, ctrl_valid=0, phase_err=0,
//    lock=0, lock counter=0. Reset mid-measurement discards the pulse.
//  - flagu/flagd each pass through a 2-flop synchronizer -> fu_s, fd_s.
//  - FSM states IDLE, MEAS_UP, MEAS_DN, UPDATE:
//    IDLE:    fu_s&~fd_s -> MEAS_UP, width=1. fd_s&~fu_s -> MEAS_DN, width=1.
//             fu_s&fd_s in the same cycle -> UPDATE with err=0.
//    MEAS_UP: width++ (saturate at 2^WW-1) while fu_s; fd_s ignored.
//             ~fu_s -> UPDATE, err=+width.
//    MEAS_DN: mirror of MEAS_UP, err=-width.
//    UPDATE:  one cycle; next state IDLE. A new pulse is ignored until IDLE.
//  - Arithmetic, signed, CW+3 bits internal:
//      integ' = sat(integ + (err <<< KI_SHIFT))
//      ctrl   = sat(integ' + (err <<< KP_SHIFT))
//    sat clamps to [0, 2^CW-1]. The integrator holds clamped values and
//    does not wind up beyond those limits.
//  - Timing: ctrl_word, phase_err and integ are registered on the clk edge
//    that leaves UPDATE. ctrl_valid=1 in that same following cycle only.
//    Pulse end to output is 2 clk after the first fu_s/fd_s low sample:
//    edge -> UPDATE, then edge -> outputs.
//  - Lock: on each update, if |err|<=LOCK_TOL the counter increments
//    (saturating at LOCK_CNT), else it clears and lock=0.
//    lock=1 while counter==LOCK_CNT. lock changes only with ctrl_valid.
//  - Sign: up (reference leads feedback) raises ctrl_word.
// STRUCTURE
//  - Shared package/header: FSM state encodings, saturation helper function,
//    default gain constants.
//  - Sub-module pfd_sync2: 2-flop synchronizer, instantiated twice.
//  - FSM, width counter, PI datapath and lock counter live in this module.
// TESTING
//  1 Hold RESET=0 for 3 clk -> ctrl_word=512, lock=0, ctrl_valid=0,
//    phase_err=0.
//  2 flagu high for 5 clk, defaults -> phase_err=+5, integ=517,
//    ctrl_word=537, single ctrl_valid. Then flagd for 3 clk -> phase_err=-3,
//    integ=514, ctrl_word=502.
//  3 20 flagu pulses of 100 clk -> width saturates at 63. ctrl_word climbs
//    and clamps at 1023, never wraps. First flagd pulse of 3 clk lowers it
//    immediately (no windup).
//  4 flagu and flagd rising together, 8 times -> phase_err=0 each time,
//    lock=1 exactly with the 8th ctrl_valid. Then flagu for 4 clk -> lock=0.
//  5 RESET=0 pulsed while in MEAS_UP -> next cycle IDLE, outputs at reset
//    values, no ctrl_valid for the aborted pulse.
//  6 flagd rising 2 clk after flagu, flagu falling first (PFD overlap)
//    -> MEAS_UP result only, err=+width of flagu.

Source files
------------

// File: rtl/pfd_loop_filter_pkg.sv
// Shared definitions for the PFD loop filter.
//   pfd_state_t : measurement FSM state encoding
//   *_DEF       : default loop gains, widths and lock criteria
//   sat_clamp   : clamps a signed value into [0, hi]
package pfd_loop_filter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEAS_UP = 2'd1,
      ST_MEAS_DN = 2'd2,
      ST_UPDATE  = 2'd3
   } pfd_state_t;

   localparam int CW_DEF        = 10;
   localparam int WW_DEF        = 6;
   localparam int KP_SHIFT_DEF  = 2;
   localparam int KI_SHIFT_DEF  = 0;
   localparam int CTRL_INIT_DEF = 512;
   localparam int LOCK_TOL_DEF  = 1;
   localparam int LOCK_CNT_DEF  = 8;

   function automatic int sat_clamp(input int v, input int hi);
      if (v < 0)
         return 0;
      else if (v > hi)
         return hi;
      else
         return v;
   endfunction

endpackage

// File: rtl/pfd_loop_filter_sync2.sv
// Two-flop synchronizer for one PFD flag.
//   clk   : filter clock
//   RESET : synchronous, active-low reset (both flops cleared)
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
module pfd_sync2 (
   input  logic clk,
   input  logic RESET,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!RESET) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pfd_loop_filter.sv
// Digital PI loop filter fed by a phase-frequency detector.
// Measures flagu/flagd pulse widths in clk cycles, turns them into a signed
// phase error, runs a saturating PI update per comparison and drives the DCO
// control word plus a lock indicator.
//   clk        : filter clock, rising edge
//   RESET      : synchronous, active-low reset
//   flagu      : PFD up pulse (asynchronous)
//   flagd      : PFD down pulse (asynchronous)
//   ctrl_word  : DCO control word, unsigned, clamped to [0, 2^CW-1]
//   ctrl_valid : one-cycle strobe when ctrl_word was just updated
//   phase_err  : signed error used by the last update
//   lock       : loop locked
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a synchronized up or down pulse
// ST_MEAS_UP | counting up-pulse width, down flag ignored
// ST_MEAS_DN | counting down-pulse width, up flag ignored
// ST_UPDATE  | error latched; PI result registered on the edge leaving
module pfd_loop_filter
   import pfd_loop_filter_pkg::*;
#(
   parameter int CW        = CW_DEF,
   parameter int WW        = WW_DEF,
   parameter int KP_SHIFT  = KP_SHIFT_DEF,
   parameter int KI_SHIFT  = KI_SHIFT_DEF,
   parameter int CTRL_INIT = CTRL_INIT_DEF,
   parameter int LOCK_TOL  = LOCK_TOL_DEF,
   parameter int LOCK_CNT  = LOCK_CNT_DEF
) (
   input  logic               clk,
   input  logic               RESET,
   input  logic               flagu,
   input  logic               flagd,
   output logic [CW-1:0]      ctrl_word,
   output logic               ctrl_valid,
   output logic signed [WW:0] phase_err,
   output logic               lock
);

   localparam int AW  = CW + 3;
   localparam int LCW = $clog2(LOCK_CNT + 1);
   localparam int CTRL_MAX = (2 ** CW) - 1;
   localparam logic [WW-1:0]  W_MAX    = '1;
   localparam logic [LCW-1:0] LOCK_TOP = LCW'(LOCK_CNT);

   logic fu_s;
   logic fd_s;

   pfd_sync2 u_sync_up (
      .clk   (clk),
      .RESET (RESET),
      .d     (flagu),
      .q     (fu_s)
   );

   pfd_sync2 u_sync_dn (
      .clk   (clk),
      .RESET (RESET),
      .d     (flagd),
      .q     (fd_s)
   );

   pfd_state_t         state, state_nxt;
   logic [WW-1:0]      width, width_nxt;
   logic signed [WW:0] err_q, err_nxt;

   always_ff @(posedge clk) begin
      if (!RESET) begin
         state <= ST_IDLE;
         width <= '0;
         err_q <= '0;
      end else begin
         state <= state_nxt;
         width <= width_nxt;
         err_q <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      width_nxt = width;
      err_nxt   = err_q;
      case (state)
         ST_IDLE: begin
            if (fu_s && !fd_s) begin
               state_nxt = ST_MEAS_UP;
               width_nxt = WW'(1);
            end else if (fd_s && !fu_s) begin
               state_nxt = ST_MEAS_DN;
               width_nxt = WW'(1);
            end else if (fu_s && fd_s) begin
               state_nxt = ST_UPDATE;
               err_nxt   = '0;
            end
         end
         ST_MEAS_UP: begin
            if (fu_s) begin
               if (width != W_MAX)
                  width_nxt = width + 1'b1;
            end else begin
               state_nxt = ST_UPDATE;
               err_nxt   = $signed({1'b0, width});
            end
         end
         ST_MEAS_DN: begin
            if (fd_s) begin
               if (width != W_MAX)
                  width_nxt = width + 1'b1;
            end else begin
               state_nxt = ST_UPDATE;
               err_nxt   = -$signed({1'b0, width});
            end
         end
         ST_UPDATE: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // PI datapath: integrator is clamped before the proportional term is added,
   // so a long saturated excursion leaves no stored windup.
   logic [CW-1:0]        integ;
   logic signed [AW-1:0] err_ext;
   logic signed [AW-1:0] integ_sum;
   logic signed [AW-1:0] ctrl_sum;
   logic [CW-1:0]        integ_new;
   logic [CW-1:0]        ctrl_new;

   always_comb begin
      err_ext   = {{(AW-WW-1){err_q[WW]}}, err_q};
      integ_sum = $signed({3'b000, integ}) + (err_ext <<< KI_SHIFT);
      integ_new = CW'(sat_clamp(int'(integ_sum), CTRL_MAX));
      ctrl_sum  = $signed({3'b000, integ_new}) + (err_ext <<< KP_SHIFT);
      ctrl_new  = CW'(sat_clamp(int'(ctrl_sum), CTRL_MAX));
   end

   logic           in_tol;
   logic [LCW-1:0] lock_cnt, lock_cnt_nxt;

   assign in_tol = (int'(err_q) <= LOCK_TOL) && (int'(err_q) >= -LOCK_TOL);

   always_comb begin
      lock_cnt_nxt = '0;
      if (in_tol)
         lock_cnt_nxt = (lock_cnt == LOCK_TOP) ? lock_cnt : lock_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!RESET) begin
         integ      <= CW'(CTRL_INIT);
         ctrl_word  <= CW'(CTRL_INIT);
         ctrl_valid <= 1'b0;
         phase_err  <= '0;
         lock_cnt   <= '0;
      end else begin
         ctrl_valid <= (state == ST_UPDATE);
         if (state == ST_UPDATE) begin
            integ     <= integ_new;
            ctrl_word <= ctrl_new;
            phase_err <= err_q;
            lock_cnt  <= lock_cnt_nxt;
         end
      end
   end

   // lock_cnt only moves on update edges, so lock follows ctrl_valid.
   assign lock = (lock_cnt == LOCK_TOP);

endmodule

// File: tb/tb_pfd_loop_filter.sv
// Self-checking bench for pfd_loop_filter. Pulses are generated as whole
// transactions; the model predicts the error of each pulse, the cycle its
// result appears, and the resulting PI/lock outputs with plain arithmetic.
module tb_pfd_loop_filter;

   logic              clk = 1'b0;
   logic              RESET;
   logic              flagu;
   logic              flagd;
   logic [9:0]        ctrl_word;
   logic              ctrl_valid;
   logic signed [6:0] phase_err;
   logic              lock;

   always #5 clk = ~clk;

   pfd_loop_filter dut (
      .clk        (clk),
      .RESET      (RESET),
      .flagu      (flagu),
      .flagd      (flagd),
      .ctrl_word  (ctrl_word),
      .ctrl_valid (ctrl_valid),
      .phase_err  (phase_err),
      .lock       (lock)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int at;
      int err;
   } txn_t;

   txn_t q[$];
   txn_t t;

   int m_integ = 512;
   int m_ctrl  = 512;
   int m_err   = 0;
   int m_lcnt  = 0;
   int m_valid = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int clamp(input int v);
      if (v < 0) return 0;
      if (v > 1023) return 1023;
      return v;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // per-cycle compare against the model
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         m_valid = 0;
         if (q.size() > 0 && q[0].at == cyc) begin
            t       = q.pop_front();
            m_err   = t.err;
            m_integ = clamp(m_integ + t.err);
            m_ctrl  = clamp(m_integ + t.err * 4);
            if (iabs(t.err) <= 1)
               m_lcnt = (m_lcnt >= 8) ? 8 : m_lcnt + 1;
            else
               m_lcnt = 0;
            m_valid = 1;
         end
         chk("ctrl_valid", int'(ctrl_valid), m_valid);
         chk("ctrl_word", int'(ctrl_word), m_ctrl);
         chk("phase_err", int'(phase_err), m_err);
         chk("lock", int'(lock), (m_lcnt == 8) ? 1 : 0);
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // All drive tasks start and end on a negedge.
   task automatic gap(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int at, input int err);
      txn_t x;
      x.at  = at;
      x.err = err;
      q.push_back(x);
   endtask

   task automatic up_pulse(input int len);
      int k;
      k = cyc + 1;
      flagu = 1'b1;
      repeat (len) @(negedge clk);
      flagu = 1'b0;
      push(k + len + 3, (len > 63) ? 63 : len);
   endtask

   task automatic dn_pulse(input int len);
      int k;
      k = cyc + 1;
      flagd = 1'b1;
      repeat (len) @(negedge clk);
      flagd = 1'b0;
      push(k + len + 3, (len > 63) ? -63 : -len);
   endtask

   task automatic both_pulse();
      int k;
      k = cyc + 1;
      flagu = 1'b1;
      flagd = 1'b1;
      @(negedge clk);
      flagu = 1'b0;
      flagd = 1'b0;
      push(k + 3, 0);
   endtask

   // flagd rises 2 clk after flagu and falls 1 clk after it (len >= 3)
   task automatic overlap_pulse(input int len);
      int k;
      k = cyc + 1;
      flagu = 1'b1;
      repeat (2) @(negedge clk);
      flagd = 1'b1;
      repeat (len - 2) @(negedge clk);
      flagu = 1'b0;
      @(negedge clk);
      flagd = 1'b0;
      push(k + len + 3, (len > 63) ? 63 : len);
   endtask

   task automatic reset_mid_pulse(input int len);
      flagu = 1'b1;
      repeat (len) @(negedge clk);
      RESET   = 1'b0;
      flagu   = 1'b0;
      q.delete();
      m_integ = 512;
      m_ctrl  = 512;
      m_err   = 0;
      m_lcnt  = 0;
      @(negedge clk);
      RESET = 1'b1;
   endtask

   initial begin
      RESET = 1'b0;
      flagu = 1'b0;
      flagd = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ctrl_word", int'(ctrl_word), 512);
      chk("rst_lock", int'(lock), 0);
      chk("rst_ctrl_valid", int'(ctrl_valid), 0);
      chk("rst_phase_err", int'(phase_err), 0);
      RESET = 1'b1;
      gap(4);

      up_pulse(5);
      gap(6);
      chk("up5_phase_err", int'(phase_err), 5);
      chk("up5_ctrl_word", int'(ctrl_word), 537);
      chk("up5_model_integ", m_integ, 517);
      dn_pulse(3);
      gap(6);
      chk("dn3_phase_err", int'(phase_err), -3);
      chk("dn3_ctrl_word", int'(ctrl_word), 502);
      chk("dn3_model_integ", m_integ, 514);

      repeat (20) begin
         up_pulse(100);
         gap(5);
      end
      chk("sat_phase_err", int'(phase_err), 63);
      chk("sat_ctrl_word", int'(ctrl_word), 1023);
      dn_pulse(3);
      gap(6);
      chk("nowindup_ctrl_word", int'(ctrl_word), 1008);

      for (int i = 0; i < 8; i++) begin
         both_pulse();
         gap(6);
         chk("both_phase_err", int'(phase_err), 0);
         chk("both_lock", int'(lock), (i == 7) ? 1 : 0);
      end
      up_pulse(4);
      gap(6);
      chk("unlock_lock", int'(lock), 0);
      chk("unlock_phase_err", int'(phase_err), 4);

      up_pulse(7);
      gap(6);
      reset_mid_pulse(5);
      chk("abort_ctrl_word", int'(ctrl_word), 512);
      chk("abort_phase_err", int'(phase_err), 0);
      chk("abort_ctrl_valid", int'(ctrl_valid), 0);
      gap(10);

      overlap_pulse(10);
      gap(6);
      chk("overlap_phase_err", int'(phase_err), 10);
      chk("overlap_ctrl_word", int'(ctrl_word), 562);

      repeat (80) begin
         case ($urandom_range(0, 9))
            0, 1, 2: up_pulse($urandom_range(1, 80));
            3, 4, 5: dn_pulse($urandom_range(1, 80));
            6:       both_pulse();
            7, 8:    overlap_pulse($urandom_range(3, 70));
            default: reset_mid_pulse($urandom_range(3, 20));
         endcase
         gap($urandom_range(5, 12));
      end

      gap(10);
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
